// File: rtl/fifo_rr_access_ctrl_if.sv
// Bundle between the round-robin fifo access controller, its requesters/consumer and the fifo.
// slave is the controller's view; master is the environment (requesters, consumer, fifo).
interface fifo_rr_access_ctrl_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 14,
    parameter int unsigned ID_WIDTH   = $clog2(NUM_REQ),
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned OCC_WIDTH  = $clog2(FIFO_DEPTH) + 1
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          cons_rd_req;
    logic                          cons_rd_valid;
    logic [DATA_WIDTH-1:0]         cons_rd_data;
    logic [ID_WIDTH-1:0]           cons_rd_id;
    logic                          fifo_wr_en;
    logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_data_in;
    logic                          fifo_rd_en;
    logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_data_out;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [OCC_WIDTH-1:0]          occupancy;

    modport slave (
        input  req_valid, req_data, cons_rd_req, fifo_data_out, fifo_full, fifo_empty,
        output req_ready, cons_rd_valid, cons_rd_data, cons_rd_id,
        output fifo_wr_en, fifo_data_in, fifo_rd_en, occupancy
    );

    modport master (
        output req_valid, req_data, cons_rd_req, fifo_data_out, fifo_full, fifo_empty,
        input  req_ready, cons_rd_valid, cons_rd_data, cons_rd_id,
        input  fifo_wr_en, fifo_data_in, fifo_rd_en, occupancy
    );
endinterface

// File: rtl/fifo_rr_access_ctrl.sv
// Shares one fifo between NUM_REQ tagged writers (round-robin) and one reader, one op per cycle,
// with a shadow occupancy count covering the fifo's lagging full/empty flags.
module fifo_rr_access_ctrl #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 14,
    parameter int unsigned ID_WIDTH   = $clog2(NUM_REQ),
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned OCC_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
    input logic                    clk,
    input logic                    rst,
    fifo_rr_access_ctrl_if.slave   bus_io
);

    typedef enum logic [1:0] {OpIdle, OpWrite, OpRead} op_e;

    op_e                   op;
    op_e                   last_op_q, last_op_d;
    logic [OCC_WIDTH-1:0]  occ_q, occ_d;
    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic                  rd_valid_q;
    logic [ID_WIDTH-1:0]   grant;
    logic [ID_WIDTH:0]     cand;
    logic                  grant_found;
    logic                  wr_ok, rd_ok;
    logic [DATA_WIDTH-1:0] payload [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_payload
        assign payload[gi] = bus_io.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        cand        = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (ID_WIDTH+1)'(k);
            if (cand >= (ID_WIDTH+1)'(NUM_REQ)) begin
                cand = cand - (ID_WIDTH+1)'(NUM_REQ);
            end
            if (!grant_found && bus_io.req_valid[cand[ID_WIDTH-1:0]]) begin
                grant       = cand[ID_WIDTH-1:0];
                grant_found = 1'b1;
            end
        end
    end

    // Shadow count guards the lagging flags; the flags guard a stale shadow right after reset.
    assign wr_ok = !rst && (|bus_io.req_valid) && (occ_q < OCC_WIDTH'(FIFO_DEPTH)) &&
                   !bus_io.fifo_full;
    assign rd_ok = !rst && bus_io.cons_rd_req && (occ_q != '0) && !bus_io.fifo_empty;

    always_comb begin
        op                  = OpIdle;
        last_op_d           = last_op_q;
        occ_d               = occ_q;
        rr_ptr_d            = rr_ptr_q;
        bus_io.req_ready    = '0;
        bus_io.fifo_wr_en   = 1'b0;
        bus_io.fifo_rd_en   = 1'b0;
        bus_io.fifo_data_in = {grant, payload[grant]};

        case ({wr_ok, rd_ok})
            2'b10:   op = OpWrite;
            2'b01:   op = OpRead;
            2'b11:   op = (last_op_q == OpWrite) ? OpRead : OpWrite;
            default: op = OpIdle;
        endcase

        case (op)
            OpWrite: begin
                bus_io.req_ready[grant] = 1'b1;
                bus_io.fifo_wr_en       = 1'b1;
                occ_d                   = occ_q + OCC_WIDTH'(1);
                rr_ptr_d  = (grant == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant + ID_WIDTH'(1);
                last_op_d = OpWrite;
            end
            OpRead: begin
                bus_io.fifo_rd_en = 1'b1;
                occ_d             = occ_q - OCC_WIDTH'(1);
                last_op_d         = OpRead;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q      <= '0;
            rr_ptr_q   <= '0;
            last_op_q  <= OpRead;
            rd_valid_q <= 1'b0;
        end else begin
            occ_q      <= occ_d;
            rr_ptr_q   <= rr_ptr_d;
            last_op_q  <= last_op_d;
            rd_valid_q <= (op == OpRead);
        end
    end

    // The fifo registers data_out on rd_en, so the word is present the cycle rd_valid_q is set.
    assign bus_io.cons_rd_valid                     = rd_valid_q;
    assign {bus_io.cons_rd_id, bus_io.cons_rd_data} = bus_io.fifo_data_out;
    assign bus_io.occupancy                         = occ_q;

endmodule
